// File: rtl/fetch_queue_pkg.sv
// Shared sizing, entry layout and helpers for the IF->ID fetch queue.
// The entry is packed {pc, inst, cond, pred_taken, bhr}, MSB first.
package fetch_queue_pkg;

    localparam int LOG_NUM_BHT_PATTERN_ENTRIES = 6;
    localparam int BHR_W                       = LOG_NUM_BHT_PATTERN_ENTRIES;
    localparam int FQ_DEPTH                    = 8;
    localparam int FQ_LOG_DEPTH                = 3;
    localparam int FQ_ENTRY_W                  = 64 + 32 + 1 + 1 + BHR_W;

    typedef logic [FQ_LOG_DEPTH-1:0] fq_ptr_t;
    typedef logic [FQ_LOG_DEPTH:0]   fq_cnt_t;

    typedef struct packed {
        logic [63:0]      pc;
        logic [31:0]      inst;
        logic             cond;
        logic             pred_taken;
        logic [BHR_W-1:0] bhr;
    } fq_entry_t;

    // Stall once fewer than two slots are free.
    localparam fq_cnt_t STALL_LEVEL = fq_cnt_t'(FQ_DEPTH - 1);

    // ID may ask for 3; it is treated as 2, and never more than is present.
    function automatic fq_cnt_t clamp_consume(input logic [1:0] rd_count,
                                              input fq_cnt_t    count);
        fq_cnt_t want;
        want = (rd_count == 2'd3) ? fq_cnt_t'(2) : fq_cnt_t'(rd_count);
        return (want > count) ? count : want;
    endfunction

endpackage

// File: rtl/fetch_queue_regfile.sv
// Fetch-queue storage: 2-write / 2-read array with no reset.
// Callers never target the same address with both write ports in one cycle.
module fq_regfile
    import fetch_queue_pkg::*;
(
    input  logic      clock,
    input  logic      we0,
    input  fq_ptr_t   waddr0,
    input  fq_entry_t wdata0,
    input  logic      we1,
    input  fq_ptr_t   waddr1,
    input  fq_entry_t wdata1,
    input  fq_ptr_t   raddr0,
    input  fq_ptr_t   raddr1,
    output fq_entry_t rdata0,
    output fq_entry_t rdata1
);

    fq_entry_t mem [FQ_DEPTH];

    always_ff @(posedge clock) begin
        if (we0) mem[waddr0] <= wdata0;
        if (we1) mem[waddr1] <= wdata1;
    end

    assign rdata0 = mem[raddr0];
    assign rdata1 = mem[raddr1];

endmodule

// File: rtl/fetch_queue.sv
// 2-wide in-order fetch queue between IF and ID; each entry carries the
// instruction, its BHT prediction and BHR snapshot. Flushed by rob_exception.
module fetch_queue
    import fetch_queue_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rob_exception,
    input  logic                    if_valid0,
    input  logic                    if_valid1,
    input  logic [63:0]             if_pc0,
    input  logic [63:0]             if_pc1,
    input  logic [31:0]             if_inst0,
    input  logic [31:0]             if_inst1,
    input  logic                    if_cond0,
    input  logic                    if_cond1,
    input  logic                    if_pred_taken0,
    input  logic                    if_pred_taken1,
    input  logic [BHR_W-1:0]        if_BHR0,
    input  logic [BHR_W-1:0]        if_BHR1,
    input  logic [1:0]              id_rd_count,
    output logic                    if_stall,
    output logic                    id_valid0,
    output logic                    id_valid1,
    output logic [63:0]             id_pc0,
    output logic [63:0]             id_pc1,
    output logic [31:0]             id_inst0,
    output logic [31:0]             id_inst1,
    output logic                    id_cond0,
    output logic                    id_cond1,
    output logic                    id_pred_taken0,
    output logic                    id_pred_taken1,
    output logic [BHR_W-1:0]        id_BHR0,
    output logic [BHR_W-1:0]        id_BHR1,
    output logic [FQ_LOG_DEPTH:0]   fq_count
);

    // Handshake: IF may present slots every cycle; they are accepted only when
    // if_stall is low (if_stall is IF's not-ready, derived from registered count).
    // ID sees id_valid0/1 and returns id_rd_count; requests beyond the valid
    // entries are clamped silently. rob_exception wins over both sides.

    fq_ptr_t   head, tail;
    fq_cnt_t   count;

    fq_entry_t in0, in1, rd0, rd1, wdata0;
    logic      keep0, keep1, we0, we1;
    fq_cnt_t   enq_n, deq_n;

    assign in0 = '{pc: if_pc0, inst: if_inst0, cond: if_cond0,
                   pred_taken: if_pred_taken0, bhr: if_BHR0};
    assign in1 = '{pc: if_pc1, inst: if_inst1, cond: if_cond1,
                   pred_taken: if_pred_taken1, bhr: if_BHR1};

    assign if_stall = (count >= STALL_LEVEL);

    // A predicted-taken branch in slot0 redirects fetch, so slot1 is wrong-path.
    always_comb begin
        keep0  = 1'b0;
        keep1  = 1'b0;
        we0    = 1'b0;
        we1    = 1'b0;
        wdata0 = in0;
        if (!if_stall && !rob_exception) begin
            keep0 = if_valid0;
            keep1 = if_valid1 && !(if_valid0 && if_cond0 && if_pred_taken0);
        end
        // Compaction: the first surviving slot always lands at tail.
        we0    = keep0 || keep1;
        we1    = keep0 && keep1;
        wdata0 = keep0 ? in0 : in1;
    end

    assign enq_n = fq_cnt_t'(we0) + fq_cnt_t'(we1);
    assign deq_n = clamp_consume(id_rd_count, count);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (rob_exception) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + fq_ptr_t'(deq_n);
            tail  <= tail + fq_ptr_t'(enq_n);
            count <= count + enq_n - deq_n;
        end
    end

    fq_regfile u_regfile (
        .clock  (clock),
        .we0    (we0),
        .waddr0 (tail),
        .wdata0 (wdata0),
        .we1    (we1),
        .waddr1 (tail + fq_ptr_t'(1)),
        .wdata1 (in1),
        .raddr0 (head),
        .raddr1 (head + fq_ptr_t'(1)),
        .rdata0 (rd0),
        .rdata1 (rd1)
    );

    assign id_valid0 = (count >= fq_cnt_t'(1));
    assign id_valid1 = (count >= fq_cnt_t'(2));
    assign fq_count  = count;

    // Data is forced to zero when absent so stale storage never leaks out.
    always_comb begin
        id_pc0         = '0;
        id_inst0       = '0;
        id_cond0       = 1'b0;
        id_pred_taken0 = 1'b0;
        id_BHR0        = '0;
        id_pc1         = '0;
        id_inst1       = '0;
        id_cond1       = 1'b0;
        id_pred_taken1 = 1'b0;
        id_BHR1        = '0;
        if (id_valid0) begin
            id_pc0         = rd0.pc;
            id_inst0       = rd0.inst;
            id_cond0       = rd0.cond;
            id_pred_taken0 = rd0.pred_taken;
            id_BHR0        = rd0.bhr;
        end
        if (id_valid1) begin
            id_pc1         = rd1.pc;
            id_inst1       = rd1.inst;
            id_cond1       = rd1.cond;
            id_pred_taken1 = rd1.pred_taken;
            id_BHR1        = rd1.bhr;
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus random traffic, checked
// against a queue-based model of the fetch queue's ordering rules.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic                  clock = 1'b0;
    logic                  reset;
    logic                  rob_exception;
    logic                  if_valid0, if_valid1;
    logic [63:0]           if_pc0, if_pc1;
    logic [31:0]           if_inst0, if_inst1;
    logic                  if_cond0, if_cond1;
    logic                  if_pred_taken0, if_pred_taken1;
    logic [BHR_W-1:0]      if_BHR0, if_BHR1;
    logic [1:0]            id_rd_count;
    logic                  if_stall;
    logic                  id_valid0, id_valid1;
    logic [63:0]           id_pc0, id_pc1;
    logic [31:0]           id_inst0, id_inst1;
    logic                  id_cond0, id_cond1;
    logic                  id_pred_taken0, id_pred_taken1;
    logic [BHR_W-1:0]      id_BHR0, id_BHR1;
    logic [FQ_LOG_DEPTH:0] fq_count;

    fetch_queue dut (
        .clock(clock), .reset(reset), .rob_exception(rob_exception),
        .if_valid0(if_valid0), .if_valid1(if_valid1),
        .if_pc0(if_pc0), .if_pc1(if_pc1),
        .if_inst0(if_inst0), .if_inst1(if_inst1),
        .if_cond0(if_cond0), .if_cond1(if_cond1),
        .if_pred_taken0(if_pred_taken0), .if_pred_taken1(if_pred_taken1),
        .if_BHR0(if_BHR0), .if_BHR1(if_BHR1),
        .id_rd_count(id_rd_count), .if_stall(if_stall),
        .id_valid0(id_valid0), .id_valid1(id_valid1),
        .id_pc0(id_pc0), .id_pc1(id_pc1),
        .id_inst0(id_inst0), .id_inst1(id_inst1),
        .id_cond0(id_cond0), .id_cond1(id_cond1),
        .id_pred_taken0(id_pred_taken0), .id_pred_taken1(id_pred_taken1),
        .id_BHR0(id_BHR0), .id_BHR1(id_BHR1),
        .fq_count(fq_count)
    );

    always #5 clock = ~clock;

    fq_entry_t exp_q[$];
    int        n_checks = 0;
    int        n_fail   = 0;
    logic [63:0] wrap_pc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        int n;
        n = exp_q.size();
        chk("fq_count", 64'(fq_count), 64'(n));
        chk("id_valid0", 64'(id_valid0), 64'(n >= 1));
        chk("id_valid1", 64'(id_valid1), 64'(n >= 2));
        chk("if_stall", 64'(if_stall), 64'((FQ_DEPTH - n) < 2));
        if (n >= 1) begin
            chk("id_pc0", id_pc0, exp_q[0].pc);
            chk("id_inst0", 64'(id_inst0), 64'(exp_q[0].inst));
            chk("id_cond0", 64'(id_cond0), 64'(exp_q[0].cond));
            chk("id_pred0", 64'(id_pred_taken0), 64'(exp_q[0].pred_taken));
            chk("id_BHR0", 64'(id_BHR0), 64'(exp_q[0].bhr));
        end
        if (n >= 2) begin
            chk("id_pc1", id_pc1, exp_q[1].pc);
            chk("id_inst1", 64'(id_inst1), 64'(exp_q[1].inst));
            chk("id_cond1", 64'(id_cond1), 64'(exp_q[1].cond));
            chk("id_pred1", 64'(id_pred_taken1), 64'(exp_q[1].pred_taken));
            chk("id_BHR1", 64'(id_BHR1), 64'(exp_q[1].bhr));
        end
    endtask

    // One clock: model the edge from the inputs currently applied, then compare.
    task automatic step();
        bit        stalled;
        int        want;
        fq_entry_t e0, e1;
        stalled = (FQ_DEPTH - exp_q.size()) < 2;
        e0 = '{pc: if_pc0, inst: if_inst0, cond: if_cond0, pred_taken: if_pred_taken0, bhr: if_BHR0};
        e1 = '{pc: if_pc1, inst: if_inst1, cond: if_cond1, pred_taken: if_pred_taken1, bhr: if_BHR1};
        want = (id_rd_count == 2'd3) ? 2 : int'(id_rd_count);
        @(posedge clock);
        #1;
        if (!reset || rob_exception) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < want && exp_q.size() > 0; i++) void'(exp_q.pop_front());
            if (!stalled) begin
                if (if_valid0) exp_q.push_back(e0);
                if (if_valid1 && !(if_valid0 && if_cond0 && if_pred_taken0)) exp_q.push_back(e1);
            end
        end
        check_outputs();
    endtask

    task automatic drive(input logic v0, input logic [63:0] pc0, input logic c0, input logic p0,
                         input logic v1, input logic [63:0] pc1, input logic [1:0] rd,
                         input logic exc);
        if_valid0      = v0;
        if_pc0         = pc0;
        if_inst0       = $urandom;
        if_cond0       = c0;
        if_pred_taken0 = p0;
        if_BHR0        = BHR_W'($urandom);
        if_valid1      = v1;
        if_pc1         = pc1;
        if_inst1       = $urandom;
        if_cond1       = 1'($urandom_range(0, 1));
        if_pred_taken1 = 1'($urandom_range(0, 1));
        if_BHR1        = BHR_W'($urandom);
        id_rd_count    = rd;
        rob_exception  = exc;
    endtask

    initial begin
        // Reset held with live slots: nothing may be accepted.
        reset = 1'b0;
        drive(1, 64'h900, 0, 0, 1, 64'h904, 2'd0, 0);
        #1;
        chk("rst_count", 64'(fq_count), 64'd0);
        chk("rst_pc0", id_pc0, 64'd0);
        repeat (3) step();
        chk("rst_stall", 64'(if_stall), 64'd0);
        chk("rst_pc1", id_pc1, 64'd0);
        @(negedge clock);
        reset = 1'b1;

        // Single enqueue of two slots, visible one cycle later.
        drive(1, 64'h100, 0, 0, 1, 64'h104, 2'd0, 0);
        step();
        chk("enq_pc0", id_pc0, 64'h100);
        chk("enq_pc1", id_pc1, 64'h104);
        drive(0, 0, 0, 0, 0, 0, 2'd3, 0);
        step();

        // Taken branch in slot0 squashes slot1.
        drive(1, 64'h200, 1, 1, 1, 64'h204, 2'd0, 0);
        step();
        chk("squash_count", 64'(fq_count), 64'd1);
        chk("squash_valid1", 64'(id_valid1), 64'd0);
        // Lone slot1 goes straight to tail.
        drive(0, 64'h300, 0, 0, 1, 64'h304, 2'd0, 0);
        step();
        chk("lone_pc1", id_pc1, 64'h304);
        drive(0, 0, 0, 0, 0, 0, 2'd2, 0);
        step();

        // Fill to full, then inputs ignored while stalled.
        for (int i = 0; i < 4; i++) begin
            drive(1, 64'h1000 + 64'(i * 8), 0, 0, 1, 64'h1004 + 64'(i * 8), 2'd0, 0);
            step();
        end
        chk("fill_stall", 64'(if_stall), 64'd1);
        drive(1, 64'hdead0, 0, 0, 1, 64'hdead4, 2'd0, 0);
        step();
        chk("fill_hold", 64'(fq_count), 64'd8);
        drive(1, 64'hbeef0, 0, 0, 1, 64'hbeef4, 2'd2, 0);
        step();
        chk("fill_drain_count", 64'(fq_count), 64'd6);
        chk("fill_stall_clear", 64'(if_stall), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 2'd3, 0);
        repeat (3) step();

        // Wrap: steady 2-in/2-out, PCs contiguous across the 7->0 boundary.
        drive(1, 64'h4000, 0, 0, 1, 64'h4004, 2'd0, 0);
        step();
        wrap_pc = 64'h4000;
        for (int i = 1; i <= 20; i++) begin
            drive(1, 64'h4000 + 64'(i * 8), 0, 0, 1, 64'h4004 + 64'(i * 8), 2'd2, 0);
            step();
            wrap_pc = wrap_pc + 64'd8;
            chk("wrap_seq0", id_pc0, wrap_pc);
            chk("wrap_seq1", id_pc1, wrap_pc + 64'd4);
        end
        drive(0, 0, 0, 0, 0, 0, 2'd2, 0);
        step();

        // Flush at count 5 with simultaneous enqueue and dequeue.
        drive(1, 64'h500, 0, 0, 1, 64'h504, 2'd0, 0); step();
        drive(1, 64'h508, 0, 0, 1, 64'h50c, 2'd0, 0); step();
        drive(1, 64'h510, 0, 0, 0, 64'h514, 2'd0, 0); step();
        chk("pre_flush_count", 64'(fq_count), 64'd5);
        drive(1, 64'h600, 0, 0, 1, 64'h604, 2'd1, 1);
        step();
        chk("flush_count", 64'(fq_count), 64'd0);
        chk("flush_valid0", 64'(id_valid0), 64'd0);
        drive(1, 64'h700, 0, 0, 0, 0, 2'd0, 0);
        step();
        chk("post_flush_pc0", id_pc0, 64'h700);

        // Random traffic with occasional flushes.
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), {$urandom, $urandom},
                  2'($urandom_range(0, 3)), ($urandom_range(0, 19) == 0));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
